inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 146 ++++++++++++++
 tb/tb_inst_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Instruction-memory loader: streams len host bytes into memory, verifies an XOR
// trailer, then releases the core from reset. Any failure leaves the core held.
module inst_loader #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [4:0]    len,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          core_rst,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, RELEASE} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [4:0]    len_q, len_d;
  logic [7:0]    checksum_q, checksum_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          err_q, err_d;
  logic          core_rst_q, core_rst_d;
  logic          wr_q, wr_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          accept, len_ok, last_word;

  assign in_ready  = (state_q == LOAD || state_q == CHECK) && !abort;
  assign accept    = in_valid && in_ready;
  assign len_ok    = (len != 5'd0) && (int'(len) <= DEPTH);
  // The counter is one bit wider than the address so a full-depth load never wraps.
  assign last_word = (int'(cnt_q) + 1) == int'(len_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    checksum_d = checksum_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    core_rst_d = core_rst_q;
    wr_d       = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d    = LOAD;
            err_d      = 1'b0;
            checksum_d = 8'd0;
            cnt_d      = '0;
            core_rst_d = 1'b1;
            len_d      = len;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d    = IDLE;
          err_d      = 1'b1;
          core_rst_d = 1'b1;
        end else if (accept) begin
          wr_d       = 1'b1;
          addr_d     = cnt_q[AW-1:0];
          wdata_d    = in_data;
          checksum_d = checksum_q ^ in_data;
          cnt_d      = cnt_q + 1'b1;
          if (last_word) state_d = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          state_d    = IDLE;
          err_d      = 1'b1;
          core_rst_d = 1'b1;
        end else if (accept) begin
          if (in_data == checksum_q) begin
            state_d    = RELEASE;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            state_d    = IDLE;
            err_d      = 1'b1;
            core_rst_d = 1'b1;
          end
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == CHECK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= 5'd0;
      checksum_q <= 8'd0;
      addr_q     <= '0;
      wdata_q    <= 8'd0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      checksum_q <= checksum_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
      wr_q       <= wr_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_wr_en = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign core_rst  = core_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_inst_loader.sv
// Randomised and directed load sessions for inst_loader, checked every cycle
// against a session-level reference model plus literal expectations.
module tb_inst_loader;
  logic       clk = 1'b0;
  logic       rst, start, abort, in_valid;
  logic [4:0] len;
  logic [7:0] in_data;
  logic       in_ready, mem_wr_en, core_rst, busy, done, err;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, checksum;

  always #5 clk = ~clk;

  inst_loader #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: session phase 0=idle 1=receiving 2=awaiting trailer 3=released
  int         m_phase = 0, m_got = 0, m_len = 0, m_writes = 0;
  logic [7:0] m_xor = 0, m_wdata = 0;
  logic [3:0] m_addr = 0;
  bit         m_err = 0, m_core = 1, m_wr = 0, m_done = 0;
  logic [7:0] exp_mem [16];
  logic [7:0] dut_mem [16];
  int         dut_writes = 0, dut_dones = 0;
  bit         chk_en = 0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = 8'd0;
      dut_mem[i] = 8'd0;
    end
  end

  always @(posedge clk) begin
    m_wr = 0;
    m_done = 0;
    if (rst) begin
      m_phase = 0; m_got = 0; m_xor = 0; m_err = 0; m_core = 1;
      m_addr = 0; m_wdata = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        if (len >= 1 && len <= 16) begin
          m_phase = 1; m_len = int'(len); m_got = 0; m_xor = 0; m_err = 0; m_core = 1;
        end else m_err = 1;
      end
    end else if (m_phase == 3) begin
      m_phase = 0;
    end else if (abort) begin
      m_phase = 0; m_err = 1; m_core = 1;
    end else if (in_valid) begin
      if (m_phase == 1) begin
        m_wr = 1; m_addr = 4'(m_got); m_wdata = in_data;
        exp_mem[m_got] = in_data;
        m_writes++;
        m_xor = m_xor ^ in_data;
        m_got++;
        if (m_got == m_len) m_phase = 2;
      end else if (in_data == m_xor) begin
        m_phase = 3; m_done = 1; m_core = 0;
      end else begin
        m_phase = 0; m_err = 1; m_core = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, (m_phase == 1 || m_phase == 2) && !abort);
      check("busy", busy, m_phase == 1 || m_phase == 2);
      check("mem_wr_en", mem_wr_en, m_wr);
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
      check("done", done, m_done);
      check("err", err, m_err);
      check("core_rst", core_rst, m_core);
      check("checksum", checksum, m_xor);
      if (mem_wr_en === 1'b1) begin
        dut_mem[mem_addr] = mem_wdata;
        dut_writes++;
      end
      if (done === 1'b1) dut_dones++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] l);
    start = 1'b1; len = l;
    tick();
    start = 1'b0; len = 5'($urandom);
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    repeat (gap) begin
      in_valid = 1'b0; in_data = 8'($urandom);
      start = ($urandom_range(0, 3) == 0); len = 5'($urandom_range(1, 16));
      tick();
    end
    start = 1'b0;
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  int w0, d0;
  logic [7:0] x, b;
  int l, ev;

  initial begin
    rst = 1; start = 0; abort = 0; in_valid = 0; len = 0; in_data = 0;
    tick(); tick();
    chk_en = 1;
    @(negedge clk);
    check("rst_core_rst", core_rst, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_mem_addr", mem_addr, 4'd0);
    check("rst_checksum", checksum, 8'd0);
    @(posedge clk); #1;
    rst = 0;
    tick();

    // Good 3-word load
    w0 = dut_writes; d0 = dut_dones;
    do_start(5'd3);
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h70, 0);
    tick(); tick();
    check("ok3_writes", dut_writes - w0, 3);
    check("ok3_mem0", dut_mem[0], 8'h12);
    check("ok3_mem1", dut_mem[1], 8'h34);
    check("ok3_mem2", dut_mem[2], 8'h56);
    check("ok3_checksum", checksum, 8'h70);
    check("ok3_dones", dut_dones - d0, 1);
    check("ok3_core_rst", core_rst, 1'b0);
    check("ok3_err", err, 1'b0);
    $display("session len=3 good trailer: err=%0b core_rst=%0b", err, core_rst);

    // Bad trailer
    w0 = dut_writes; d0 = dut_dones;
    do_start(5'd3);
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h71, 0);
    tick(); tick();
    check("bad3_writes", dut_writes - w0, 3);
    check("bad3_err", err, 1'b1);
    check("bad3_dones", dut_dones - d0, 0);
    check("bad3_core_rst", core_rst, 1'b1);
    $display("session len=3 bad trailer: err=%0b core_rst=%0b", err, core_rst);

    // Full depth with alternating valid
    w0 = dut_writes; d0 = dut_dones;
    do_start(5'd16);
    for (int i = 0; i < 16; i++) send(8'(i), 1);
    send(8'h00, 1);
    tick(); tick();
    check("full_writes", dut_writes - w0, 16);
    for (int i = 0; i < 16; i++) check("full_mem", dut_mem[i], 8'(i));
    check("full_dones", dut_dones - d0, 1);
    $display("session len=16 gapped: err=%0b core_rst=%0b", err, core_rst);

    // Illegal lengths
    w0 = dut_writes;
    do_start(5'd0);
    check("len0_err", err, 1'b1);
    check("len0_busy", busy, 1'b0);
    do_start(5'd17);
    check("len17_err", err, 1'b1);
    check("len17_busy", busy, 1'b0);
    tick();
    check("badlen_writes", dut_writes - w0, 0);
    $display("session len=0/17 rejected: err=%0b", err);

    // Abort colliding with the 2nd byte
    w0 = dut_writes;
    do_start(5'd4);
    send(8'hA1, 0);
    abort = 1; in_valid = 1; in_data = 8'hB2;
    tick();
    abort = 0; in_valid = 0;
    tick(); tick();
    check("abort_writes", dut_writes - w0, 1);
    check("abort_mem0", dut_mem[0], 8'hA1);
    check("abort_err", err, 1'b1);
    check("abort_core_rst", core_rst, 1'b1);
    check("abort_busy", busy, 1'b0);
    $display("session len=4 aborted: err=%0b core_rst=%0b", err, core_rst);

    // Reset mid-session, then a clean load
    w0 = dut_writes;
    do_start(5'd4);
    send(8'h11, 0); send(8'h22, 0);
    rst = 1; tick(); rst = 0;
    tick(); tick();
    check("rstmid_writes", dut_writes - w0, 2);
    check("rstmid_err", err, 1'b0);
    check("rstmid_core_rst", core_rst, 1'b1);
    d0 = dut_dones;
    do_start(5'd2);
    send(8'h5A, 0); send(8'hC3, 0); send(8'h99, 0);
    tick(); tick();
    check("after_rst_dones", dut_dones - d0, 1);
    check("after_rst_core_rst", core_rst, 1'b0);
    $display("session len=4 reset mid-load, recovery load: err=%0b core_rst=%0b", err, core_rst);

    // Random sessions
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 4) == 0) l = $urandom_range(0, 31);
      else l = $urandom_range(1, 16);
      do_start(5'(l));
      ev = 0;
      if (l >= 1 && l <= 16) begin
        x = 8'd0;
        for (int i = 0; i < l && ev == 0; i++) begin
          b = 8'($urandom);
          if ($urandom_range(0, 39) == 0) begin
            abort = 1; in_valid = ($urandom_range(0, 1) == 1); in_data = b;
            tick();
            abort = 0; in_valid = 0; ev = 1;
          end else if ($urandom_range(0, 59) == 0) begin
            rst = 1; tick(); rst = 0; ev = 2;
          end else begin
            send(b, $urandom_range(0, 3));
            x = x ^ b;
          end
        end
        if (ev == 0) begin
          if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
          send(x, $urandom_range(0, 3));
        end
      end
      if ($urandom_range(0, 4) == 0) begin
        abort = 1; tick(); abort = 0;
      end
      tick(); tick();
      $display("session %0d len=%0d event=%0d: err=%0b core_rst=%0b", s, l, ev, err, core_rst);
    end

    check("total_writes", dut_writes, m_writes);
    for (int i = 0; i < 16; i++) check("final_mem", dut_mem[i], exp_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
